// File: rtl/carrier_ctrl_pkg.sv
// carrier_ctrl_pkg: shared state encoding, widths and default constants for the carrier acquisition sequencer
package carrier_ctrl_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_DWELL, ST_EVAL, ST_TRACK, ST_LOCKED} state_t;
    localparam int PHASE_W = 32;
    localparam int ACC_W = 48;
    localparam logic [PHASE_W-1:0] STEP_DEF = 32'h1000_0000;
    localparam logic [PHASE_W-1:0] LOCK_THR_DEF = 32'h0100_0000;
    localparam int LOCK_CNT_DEF = 32;
    localparam int LOSS_CNT_DEF = 8;
endpackage

// File: rtl/carrier_peak_search.sv
// carrier_peak_search: dwell energy accumulator with running max / arg-max over grid points
// clk, reset      : clock, synchronous active-high reset
// clr_best        : new search, clears best_acc (best_idx stays visible until the first eval)
// acc_clr, acc_en : clear / accumulate mag into the dwell accumulator
// eval, idx       : compare the finished dwell of grid point idx against the best so far
// best_idx        : registered winner; win_idx: winner including the eval in progress
module carrier_peak_search
    import carrier_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_best,
    input  logic               acc_clr,
    input  logic               acc_en,
    input  logic               eval,
    input  logic [PHASE_W-1:0] mag,
    input  logic [7:0]         idx,
    output logic [7:0]         best_idx,
    output logic [7:0]         win_idx
);
    logic [ACC_W-1:0] acc, best_acc;
    logic take;
    // strict compare so ties keep the earlier grid point
    assign take = idx == 8'd0 || acc > best_acc;
    assign win_idx = take ? idx : best_idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            best_acc <= '0;
            best_idx <= '0;
        end else begin
            acc <= acc_clr ? '0 : acc_en ? acc + ACC_W'(mag) : acc;
            if (clr_best) best_acc <= '0;
            else if (eval && take) begin
                best_acc <= acc;
                best_idx <= idx;
            end
        end
    end
endmodule

// File: rtl/carrier_acq_ctrl.sv
// carrier_acq_ctrl: coarse phase search, settle, proportional tracking and lock detection for the carrier NCO
// clk, reset            : clock, synchronous active-high reset
// start, stop           : begin acquisition (IDLE only) / abort to IDLE from anywhere
// corr_valid, corr_mag  : unsigned correlation energy from the demodulator
// err_valid, err_in     : signed phase error from the demodulator
// phi_est               : phase offset to the NCO
// busy, locked          : not IDLE / in LOCKED
// search_done, lost     : one-cycle pulses on search completion / lock loss
// best_idx              : winning grid index of the last search
module carrier_acq_ctrl
    import carrier_ctrl_pkg::*;
#(
    parameter int                 NUM_STEPS = 16,
    parameter logic [PHASE_W-1:0] STEP      = STEP_DEF,
    parameter int                 SETTLE    = 4,
    parameter int                 DWELL     = 64,
    parameter int                 KP_SHIFT  = 4,
    parameter logic [PHASE_W-1:0] LOCK_THR  = LOCK_THR_DEF,
    parameter int                 LOCK_CNT  = LOCK_CNT_DEF,
    parameter int                 LOSS_CNT  = LOSS_CNT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               corr_valid,
    input  logic [PHASE_W-1:0] corr_mag,
    input  logic               err_valid,
    input  logic [PHASE_W-1:0] err_in,
    output logic [PHASE_W-1:0] phi_est,
    output logic               busy,
    output logic               locked,
    output logic               search_done,
    output logic               lost,
    output logic [7:0]         best_idx
);
    state_t state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [7:0] step_idx, step_n, win_idx;
    logic [PHASE_W-1:0] phi_n, kp;
    logic [PHASE_W:0] err_x, err_abs;
    logic done_n, lost_n, restart, acc_clr, acc_en, eval, good;

    carrier_peak_search u_peak (
        .clk(clk), .reset(reset), .clr_best(restart), .acc_clr(acc_clr), .acc_en(acc_en),
        .eval(eval), .mag(corr_mag), .idx(step_idx), .best_idx(best_idx), .win_idx(win_idx)
    );

    // 33-bit magnitude so that -2^31 maps to +2^31 instead of wrapping
    assign err_x = {err_in[PHASE_W-1], err_in};
    assign err_abs = err_x[PHASE_W] ? -err_x : err_x;
    assign good = err_abs < {1'b0, LOCK_THR};
    assign kp = $signed(err_in) >>> KP_SHIFT;
    assign busy = state != ST_IDLE;
    assign locked = state == ST_LOCKED;

    // one counter serves settle, dwell, good-run and bad-run counting; the states never overlap
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        step_n = step_idx;
        phi_n = phi_est;
        done_n = 1'b0;
        lost_n = 1'b0;
        restart = 1'b0;
        acc_clr = 1'b0;
        eval = 1'b0;
        acc_en = state == ST_DWELL && corr_valid;
        if (stop) state_n = ST_IDLE;
        else case (state)
            ST_IDLE: restart = start;
            ST_SETTLE: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(SETTLE - 1)) begin
                    state_n = ST_DWELL;
                    cnt_n = '0;
                    acc_clr = 1'b1;
                end
            end
            ST_DWELL: if (corr_valid) begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(DWELL - 1)) begin
                    state_n = ST_EVAL;
                    cnt_n = '0;
                end
            end
            ST_EVAL: begin
                eval = 1'b1;
                cnt_n = '0;
                if (step_idx == 8'(NUM_STEPS - 1)) begin
                    phi_n = PHASE_W'(win_idx) * STEP;
                    done_n = 1'b1;
                    state_n = ST_TRACK;
                end else begin
                    step_n = step_idx + 8'd1;
                    phi_n = phi_est + STEP;
                    state_n = ST_SETTLE;
                end
            end
            ST_TRACK: if (err_valid) begin
                phi_n = phi_est + kp;
                cnt_n = good ? cnt + 32'd1 : '0;
                if (good && cnt == 32'(LOCK_CNT - 1)) begin
                    state_n = ST_LOCKED;
                    cnt_n = '0;
                end
            end
            ST_LOCKED: if (err_valid) begin
                phi_n = phi_est + kp;
                cnt_n = good ? '0 : cnt + 32'd1;
                if (!good && cnt == 32'(LOSS_CNT - 1)) begin
                    lost_n = 1'b1;
                    restart = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (restart) begin
            state_n = ST_SETTLE;
            cnt_n = '0;
            step_n = '0;
            phi_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            step_idx <= '0;
            phi_est <= '0;
            search_done <= 1'b0;
            lost <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            step_idx <= step_n;
            phi_est <= phi_n;
            search_done <= done_n;
            lost <= lost_n;
        end
    end
endmodule
